// File: rtl/calc_pkg.sv
// Shared definitions for the result-to-BCD conversion stage:
// FSM state encoding and digit/iteration widths.
package calc_pkg;

   localparam int BCD_DIGIT_W = 4;
   localparam int CONV_WIDTH  = 32;
   localparam int CONV_ITER_W = $clog2(CONV_WIDTH);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      FINISH = 2'd2
   } conv_state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next digit.
module bcd_digit_adj
   import calc_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit_i,
   output logic [BCD_DIGIT_W-1:0] digit_o
);

   assign digit_o = (digit_i >= BCD_DIGIT_W'(5)) ? digit_i + BCD_DIGIT_W'(3) : digit_i;

endmodule

// File: rtl/result_bcd_conv.sv
// Sequential binary-to-BCD converter (one bit per clock) with sign, overflow
// and leading-zero blanking for the display driver. Optional: LEADING_ZERO_BLANK_EN.
module result_bcd_conv
   import calc_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 10
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          conv_start,
   input  logic [WIDTH-1:0]              bin_in,
   input  logic                          sign_in,
   input  logic                          ovf_in,
   output logic                          conv_busy,
   output logic                          conv_done,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
   output logic                          neg_out,
   output logic                          err_out,
   output logic [DIGITS-1:0]             blank_out
);

   localparam int BCD_W  = BCD_DIGIT_W * DIGITS;
   localparam int ITER_W = $clog2(WIDTH);

   conv_state_e       state_q, state_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic [BCD_W-1:0]  acc_q, acc_d;
   logic [WIDTH-1:0]  bin_q, bin_d;
   logic              sign_q, sign_d;
   logic              nz_q, nz_d;
   logic [BCD_W-1:0]  bcd_q, bcd_d;
   logic              neg_q, neg_d;
   logic              err_q, err_d;

   logic [BCD_W-1:0]  acc_adj;
   logic [BCD_W-1:0]  acc_shift;
   logic              unused_adj_msb;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_i (acc_q  [g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .digit_o (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   // The adjusted top digit never reaches 8 when 10^DIGITS > 2^WIDTH, so its MSB is dropped.
   assign acc_shift      = {acc_adj[BCD_W-2:0], bin_q[WIDTH-1]};
   assign unused_adj_msb = acc_adj[BCD_W-1];

`ifdef LEADING_ZERO_BLANK_EN
   logic [DIGITS-1:0] blank_q, blank_d;
   logic [DIGITS-1:0] blank_calc;
   logic              seen_nz;

   always_comb begin
      blank_calc = '0;
      seen_nz    = 1'b0;
      for (int i = DIGITS-1; i >= 1; i--) begin
         seen_nz       = seen_nz | (|acc_shift[i*BCD_DIGIT_W +: BCD_DIGIT_W]);
         blank_calc[i] = ~seen_nz;
      end
   end

   assign blank_out = blank_q;
`else
   assign blank_out = '0;
`endif

   // NOTE: every signal gets its hold value first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      acc_d   = acc_q;
      bin_d   = bin_q;
      sign_d  = sign_q;
      nz_d    = nz_q;
      bcd_d   = bcd_q;
      neg_d   = neg_q;
      err_d   = err_q;
`ifdef LEADING_ZERO_BLANK_EN
      blank_d = blank_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (conv_start) begin
               bin_d  = bin_in;
               sign_d = sign_in;
               nz_d   = |bin_in;
               acc_d  = '0;
               iter_d = '0;
               if (ovf_in) begin
                  state_d = FINISH;
                  bcd_d   = '0;
                  neg_d   = 1'b0;
                  err_d   = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
                  blank_d = {{(DIGITS-1){1'b1}}, 1'b0};
`endif
               end else begin
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            acc_d  = acc_shift;
            bin_d  = {bin_q[WIDTH-2:0], 1'b0};
            iter_d = iter_q + ITER_W'(1);
            if (iter_q == ITER_W'(WIDTH-1)) begin
               state_d = FINISH;
               bcd_d   = acc_shift;
               neg_d   = sign_q & nz_q;
               err_d   = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
               blank_d = blank_calc;
`endif
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         iter_q  <= '0;
         acc_q   <= '0;
         bin_q   <= '0;
         sign_q  <= 1'b0;
         nz_q    <= 1'b0;
         bcd_q   <= '0;
         neg_q   <= 1'b0;
         err_q   <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
         blank_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         acc_q   <= acc_d;
         bin_q   <= bin_d;
         sign_q  <= sign_d;
         nz_q    <= nz_d;
         bcd_q   <= bcd_d;
         neg_q   <= neg_d;
         err_q   <= err_d;
`ifdef LEADING_ZERO_BLANK_EN
         blank_q <= blank_d;
`endif
      end
   end

   assign conv_busy = (state_q != IDLE);
   assign conv_done = (state_q == FINISH);
   assign bcd_out   = bcd_q;
   assign neg_out   = neg_q;
   assign err_out   = err_q;

endmodule

// File: tb/tb_result_bcd_conv.sv
// Self-checking bench for result_bcd_conv: table-driven conversions checked
// through a scoreboard, plus mid-conversion start, held start and reset cases.
module tb_result_bcd_conv;

   localparam int WIDTH  = 32;
   localparam int DIGITS = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        conv_start = 1'b0;
   logic [31:0] bin_in = '0;
   logic        sign_in = 1'b0;
   logic        ovf_in = 1'b0;
   logic        conv_busy;
   logic        conv_done;
   logic [39:0] bcd_out;
   logic        neg_out;
   logic        err_out;
   logic [9:0]  blank_out;

   result_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk        (clk),
      .rst        (rst),
      .conv_start (conv_start),
      .bin_in     (bin_in),
      .sign_in    (sign_in),
      .ovf_in     (ovf_in),
      .conv_busy  (conv_busy),
      .conv_done  (conv_done),
      .bcd_out    (bcd_out),
      .neg_out    (neg_out),
      .err_out    (err_out),
      .blank_out  (blank_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] bin;
      logic        sign;
      logic        ovf;
      logic [39:0] bcd;
      logic        neg;
      logic        err;
      logic [9:0]  blank;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   vec_t sb[$];
   int   done_seen = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [9:0] blank_model(input logic [39:0] bcd, input logic ovf);
      logic [9:0] b;
      b = '0;
`ifdef LEADING_ZERO_BLANK_EN
      if (ovf) return 10'h3FE;
      for (int i = 9; i >= 1; i--) begin
         if (bcd[i*4 +: 4] != 4'd0) break;
         b[i] = 1'b1;
      end
`else
      if (ovf) b = '0;
      if (bcd != '0) b = '0;
`endif
      return b;
   endfunction

   function automatic vec_t make_vec(input logic [31:0] bin, input logic sign, input logic ovf);
      vec_t            r;
      longint unsigned v;
      r.bin  = bin;
      r.sign = sign;
      r.ovf  = ovf;
      r.bcd  = '0;
      v      = longint'(bin);
      if (!ovf) begin
         for (int i = 0; i < 10; i++) begin
            r.bcd[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
         end
      end
      r.neg   = ovf ? 1'b0 : (sign && bin != 0);
      r.err   = ovf;
      r.blank = blank_model(r.bcd, ovf);
      return r;
   endfunction

   // Scoreboard: each done pulse is compared against the oldest pending expectation.
   always @(negedge clk) begin
      vec_t e;
      if (rst && conv_done) begin
         done_seen++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done pulse, expected no pending conversion");
         end else begin
            e = sb.pop_front();
            check("bcd_out",   64'(bcd_out),   64'(e.bcd));
            check("neg_out",   64'(neg_out),   64'(e.neg));
            check("err_out",   64'(err_out),   64'(e.err));
            check("blank_out", 64'(blank_out), 64'(e.blank));
         end
      end
   end

   task automatic run_conv(input vec_t v, input int exp_lat, input int mid_pulse_at);
      int done_at;
      bit busy_ok;
      sb.push_back(v);
      @(negedge clk);
      bin_in     = v.bin;
      sign_in    = v.sign;
      ovf_in     = v.ovf;
      conv_start = 1'b1;
      @(posedge clk);
      done_at = 0;
      busy_ok = 1'b1;
      for (int k = 1; k <= 100 && done_at == 0; k++) begin
         @(negedge clk);
         if (k == 1) begin
            conv_start = 1'b0;
            bin_in     = $urandom;
            sign_in    = 1'($urandom);
         end
         if (k == mid_pulse_at) begin
            conv_start = 1'b1;
            ovf_in     = 1'b1;
         end
         if (k == mid_pulse_at + 1) begin
            conv_start = 1'b0;
            ovf_in     = 1'b0;
         end
         if (!conv_busy) busy_ok = 1'b0;
         if (conv_done) done_at = k;
      end
      check("latency", 64'(done_at), 64'(exp_lat));
      check("busy_during", 64'(busy_ok), 64'd1);
      @(negedge clk);
      check("done_single_cycle", 64'(conv_done), 64'd0);
      check("busy_after", 64'(conv_busy), 64'd0);
      repeat (3) @(negedge clk);
      check("hold_bcd", 64'(bcd_out), 64'(v.bcd));
      check("hold_err", 64'(err_out), 64'(v.err));
   endtask

   vec_t tbl[10];

   initial begin
      int   first_done, second_done, dones_before;
      vec_t hv;

      tbl[0] = make_vec(32'd0, 1'b1, 1'b0);
      tbl[1] = '{32'hFFFF_FFFF, 1'b0, 1'b0, 40'h42_9496_7295, 1'b0, 1'b0, 10'h000};
`ifdef LEADING_ZERO_BLANK_EN
      tbl[2] = '{32'd65536, 1'b1, 1'b0, 40'h00_0006_5536, 1'b1, 1'b0, 10'h3E0};
`else
      tbl[2] = '{32'd65536, 1'b1, 1'b0, 40'h00_0006_5536, 1'b1, 1'b0, 10'h000};
`endif
      tbl[3] = make_vec(32'd1234, 1'b1, 1'b1);
      tbl[4] = make_vec(32'd12345, 1'b0, 1'b0);
      tbl[5] = make_vec(32'd1, 1'b1, 1'b0);
      tbl[6] = make_vec(32'd999_999_999, 1'b0, 1'b0);
      tbl[7] = make_vec(32'd1_000_000_000, 1'b1, 1'b0);
      tbl[8] = make_vec($urandom, 1'($urandom), 1'b0);
      tbl[9] = make_vec($urandom_range(0, 99_999), 1'b1, 1'b0);

      repeat (3) @(negedge clk);
      check("rst_busy",  64'(conv_busy), 64'd0);
      check("rst_done",  64'(conv_done), 64'd0);
      check("rst_bcd",   64'(bcd_out),   64'd0);
      check("rst_neg",   64'(neg_out),   64'd0);
      check("rst_err",   64'(err_out),   64'd0);
      check("rst_blank", 64'(blank_out), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 10; i++)
         run_conv(tbl[i], tbl[i].ovf ? 1 : 33, 0);

      // Start pulsed mid-conversion must be ignored.
      dones_before = done_seen;
      run_conv(make_vec(32'd87_654_321, 1'b1, 1'b0), 33, 10);
      check("mid_start_one_done", 64'(done_seen - dones_before), 64'd1);

      // Start held high re-triggers on the first IDLE cycle after FINISH.
      hv = make_vec(32'd4_000_000_001, 1'b0, 1'b0);
      sb.push_back(hv);
      sb.push_back(hv);
      @(negedge clk);
      bin_in = hv.bin; sign_in = hv.sign; ovf_in = 1'b0; conv_start = 1'b1;
      @(posedge clk);
      first_done  = 0;
      second_done = 0;
      for (int k = 1; k <= 150 && second_done == 0; k++) begin
         @(negedge clk);
         if (conv_done) begin
            if (first_done == 0) first_done = k;
            else second_done = k;
         end
         if (first_done != 0 && k == first_done + 2) conv_start = 1'b0;
      end
      conv_start = 1'b0;
      check("held_first_done",  64'(first_done),  64'd33);
      check("held_second_done", 64'(second_done), 64'd67);

      // Reset mid-conversion aborts with no done pulse.
      repeat (2) @(negedge clk);
      dones_before = done_seen;
      sb.push_back(make_vec(32'd55_555, 1'b0, 1'b0));
      bin_in = 32'd55_555; sign_in = 1'b0; ovf_in = 1'b0; conv_start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (k == 1) conv_start = 1'b0;
      end
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      check("arst_busy",  64'(conv_busy), 64'd0);
      check("arst_done",  64'(conv_done), 64'd0);
      check("arst_bcd",   64'(bcd_out),   64'd0);
      check("arst_neg",   64'(neg_out),   64'd0);
      check("arst_err",   64'(err_out),   64'd0);
      check("arst_blank", 64'(blank_out), 64'd0);
      rst = 1'b1;
      repeat (40) @(negedge clk);
      check("no_done_after_reset", 64'(done_seen - dones_before), 64'd0);
      run_conv(make_vec(32'd2_147_483_648, 1'b1, 1'b0), 33, 0);

      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "watchdog expired");
   end

endmodule
